// File: rtl/instr_encoder_if.sv
// Field-set in / encoded-word out bundle for instr_encoder; master drives fields and out_ready.
// out_addr exists only when INSTR_ENC_ADDR_EN is defined.
interface instr_encoder_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_op;
    logic [4:0]               in_rs;
    logic [4:0]               in_rt;
    logic [4:0]               in_rd;
    logic [5:0]               in_funct;
    logic [15:0]              in_imm;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [$clog2(DEPTH):0]   out_count;
`ifdef INSTR_ENC_ADDR_EN
    logic [31:0]              out_addr;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_count, out_addr
    );
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_count, out_addr
    );
`else
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_count
    );
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_count
    );
`endif
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS field sets into 32-bit words and buffers them in a DEPTH-entry FIFO.
// Latency: one cycle from acceptance to out_valid when the FIFO is empty.
// Backpressure: in_ready drops when full (no pass-through); head word holds while out_ready=0.
// Optional INSTR_ENC_ADDR_EN adds out_addr, a byte-address counter stepped by 4 per output transfer.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    instr_encoder_if.slave bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = DEPTH[PW:0];

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic          started;
    logic [31:0]   encWord;
    logic          pushEn;
    logic          popEn;

    function automatic logic [5:0] opcodeOf(input logic [2:0] op);
        case (op)
            3'd0:    opcodeOf = 6'b000000;
            3'd1:    opcodeOf = 6'b001000;
            3'd2:    opcodeOf = 6'b100011;
            3'd3:    opcodeOf = 6'b101011;
            3'd4:    opcodeOf = 6'b001100;
            3'd5:    opcodeOf = 6'b001101;
            3'd6:    opcodeOf = 6'b000100;
            default: opcodeOf = 6'b000101;
        endcase
    endfunction

    always_comb begin
        encWord = {opcodeOf(bus.in_op), bus.in_rs, bus.in_rt, bus.in_imm};
        if (bus.in_op == 3'd0) begin
            encWord = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
        end
    end

    // started keeps in_ready low until the first edge after reset release.
    assign bus.in_ready  = started && (count != FULL);
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? mem[rdPtr] : 32'h0;
    assign bus.out_count = count;

    assign pushEn = bus.in_valid  && bus.in_ready;
    assign popEn  = bus.out_valid && bus.out_ready;

    // Storage needs no reset: out_instr is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr] <= encWord;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_ENC_ADDR_EN
    logic [31:0] addrReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrReg <= ADDR_BASE;
        end else if (popEn) begin
            addrReg <= addrReg + 32'd4;
        end
    end

    assign bus.out_addr = addrReg;
`endif
endmodule
